// File: rtl/riscv_ifetch_pkg.sv
// Shared RV32I front-end definitions: system-instruction encodings, fetch FSM states, IF/ID payload.
// Default memory geometry and reset vector, used when the core top instantiates the fetch stage.
package riscv_defs;

    localparam int          IF_NB_ADDR    = 32;
    localparam int          IF_NB_INSTR   = 32;
    localparam int          IF_IMEM_DEPTH = 256;
    localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {IF_BOOT, IF_RUN, IF_HALT} ifetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/riscv_ifetch.sv
// Fetch stage: owns the PC and addresses the synchronous imem with next_pc, so the read data always matches pc_q.
// One cycle from address to o_instr; stall holds the PC (the same word is re-read), redirect kills the current slot.
module riscv_ifetch
    import riscv_defs::*;
#(
    parameter int                 NB_ADDR    = IF_NB_ADDR,
    parameter int                 NB_INSTR   = IF_NB_INSTR,
    parameter int                 IMEM_DEPTH = IF_IMEM_DEPTH,
    parameter logic [NB_ADDR-1:0] RESET_PC   = IF_RESET_PC
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_stall,
    input  logic                          i_redirect,
    input  logic [NB_ADDR-1:0]            i_redirect_pc,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
    input  logic [NB_INSTR-1:0]           i_imem_data,
    output logic [NB_INSTR-1:0]           o_instr,
    output logic [NB_ADDR-1:0]            o_pc,
    output logic [NB_ADDR-1:0]            o_pc_plus4,
    output logic                          o_valid,
    output logic                          o_halted,
    output logic                          o_fault,
    output logic [31:0]                   o_fetch_count
);

    localparam int                 AW       = $clog2(IMEM_DEPTH);
    localparam logic [NB_ADDR-1:0] PC_LIMIT = NB_ADDR'(IMEM_DEPTH * 4);

    ifetch_state_t      state_q;
    logic [NB_ADDR-1:0] pc_q;
    logic [NB_ADDR-1:0] next_pc;
    logic               halted_q;
    logic               fault_q;
    logic [31:0]        count_q;

    logic   fault_now;
    logic   out_valid;
    logic   accept;
    logic   is_system;
    logic   halt_now;
    if_id_t if_id;

    // The range check fires before a wrapped pc+4 could ever be fetched.
    assign fault_now = (state_q == IF_RUN) &&
                       ((pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT));
    assign out_valid = (state_q == IF_RUN) && !fault_now && !i_redirect;
    assign accept    = out_valid && !i_stall;
    assign is_system = (i_imem_data == ECALL_INSTR) || (i_imem_data == EBREAK_INSTR);
    assign halt_now  = accept && is_system;

    always_comb begin
        next_pc = pc_q;
        if (i_reset) begin
            next_pc = RESET_PC;
        end else if (state_q != IF_HALT && !fault_now) begin
            if (i_redirect) begin
                next_pc = i_redirect_pc;
            end else if (state_q == IF_RUN && !i_stall && !halt_now) begin
                next_pc = pc_q + NB_ADDR'(4);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        pc_q <= next_pc;
        if (i_reset) begin
            state_q  <= IF_BOOT;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
            case (state_q)
                IF_BOOT: state_q <= IF_RUN;
                IF_RUN: begin
                    if (fault_now) begin
                        fault_q <= 1'b1;
                        state_q <= IF_HALT;
                    end else if (halt_now) begin
                        halted_q <= 1'b1;
                        state_q  <= IF_HALT;
                    end
                end
                default: state_q <= IF_HALT;
            endcase
        end
    end

    always_comb begin
        if_id.instr    = out_valid ? i_imem_data : NOP_INSTR;
        if_id.pc       = pc_q;
        if_id.pc_plus4 = pc_q + NB_ADDR'(4);
        if_id.valid    = out_valid;
    end

    assign o_imem_addr   = next_pc[2 +: AW];
    assign o_instr       = if_id.instr;
    assign o_pc          = if_id.pc;
    assign o_pc_plus4    = if_id.pc_plus4;
    assign o_valid       = if_id.valid;
    assign o_halted      = halted_q;
    assign o_fault       = fault_q || fault_now;
    assign o_fetch_count = count_q;

endmodule
